cam_update_all_loader: RTL and testbench



---
 rtl/cam_pkg.sv | 10 +
 rtl/cam_update_all_loader_if.sv | 17 +
 rtl/cam_beat_serializer.sv | 34 +++
 rtl/cam_update_all_loader.sv | 83 ++++++++
 tb/tb_cam_update_all_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared CAM opcodes and loader state encoding.
//   OP_*           FSM opcode constants driven on the state input
//   loader_state_e internal UPDATE_ALL loader states
package cam_pkg;
  localparam int OP_IDLE       = 0;
  localparam int OP_UPDATE_ALL = 1;
  localparam int OP_SEARCH     = 2;
  localparam int OP_UPDATE_ONE = 3;
  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_DRAIN, L_DONE} loader_state_e;
endpackage

// File: rtl/cam_update_all_loader_if.sv
// cam_update_all_loader_if: beat input stream plus CAM write port.
//   data_in/data_in_valid/in_ready  beat handshake (master drives data/valid)
//   wr_en/wr_addr/wr_data           CAM array write port (slave drives)
interface cam_update_all_loader_if #(
  parameter int C_DATA_WIDTH = 512,
  parameter int ENTRY_WIDTH  = 32,
  parameter int CAM_DEPTH    = 64
);
  logic [C_DATA_WIDTH-1:0]      data_in;
  logic                         data_in_valid;
  logic                         in_ready;
  logic                         wr_en;
  logic [$clog2(CAM_DEPTH)-1:0] wr_addr;
  logic [ENTRY_WIDTH-1:0]       wr_data;
  modport master (output data_in, data_in_valid, input in_ready, wr_en, wr_addr, wr_data);
  modport slave  (input data_in, data_in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_beat_serializer.sv
// cam_beat_serializer: holds one beat and emits its entries one per step.
//   load_i  capture beat_i and restart at entry 0
//   step_i  advance to the next entry
//   entry_o current entry, last_o high on the final entry of the beat
module cam_beat_serializer #(
  parameter int C_DATA_WIDTH = 512,
  parameter int ENTRY_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [C_DATA_WIDTH-1:0] beat_i,
  output logic [ENTRY_WIDTH-1:0]  entry_o,
  output logic                    last_o
);
  localparam int EPB = C_DATA_WIDTH / ENTRY_WIDTH;
  localparam int IW  = EPB > 1 ? $clog2(EPB) : 1;
  logic [EPB-1:0][ENTRY_WIDTH-1:0] buf_q;
  logic [IW-1:0]                   idx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      buf_q <= beat_i;
      idx_q <= '0;
    end else if (step_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end
  assign entry_o = buf_q[idx_q];
  assign last_o  = idx_q == IW'(EPB - 1);
endmodule

// File: rtl/cam_update_all_loader.sv
// cam_update_all_loader: unpacks UPDATE_ALL beats into sequential CAM writes.
//   clk/rst         clock, synchronous active-high reset
//   state           command FSM state (1 = UPDATE_ALL)
//   bus             beat stream in, CAM write port out
//   update_all_end  one-cycle pulse after the write to address CAM_DEPTH-1
//   load_cycles     load duration when CAM_LOAD_PERF_CNT_EN is defined, else 0
module cam_update_all_loader
  import cam_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 512,
  parameter int OP_CODE_WIDTH = 3,
  parameter int ENTRY_WIDTH   = 32,
  parameter int CAM_DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OP_CODE_WIDTH-1:0] state,
  cam_update_all_loader_if.slave   bus,
  output logic                     update_all_end,
  output logic [31:0]              load_cycles
);
  localparam int AW = $clog2(CAM_DEPTH);
  loader_state_e st_q;
  logic [AW-1:0] addr_q;
  logic          end_q;
  logic          upd;
  logic          last;
  assign upd            = state == OP_CODE_WIDTH'(OP_UPDATE_ALL);
  assign bus.in_ready   = st_q == L_WAIT;
  assign bus.wr_en      = st_q == L_DRAIN;
  assign bus.wr_addr    = addr_q;
  assign update_all_end = end_q;
  cam_beat_serializer #(.C_DATA_WIDTH(C_DATA_WIDTH), .ENTRY_WIDTH(ENTRY_WIDTH)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (bus.in_ready && bus.data_in_valid && upd),
    .step_i  (bus.wr_en),
    .beat_i  (bus.data_in),
    .entry_o (bus.wr_data),
    .last_o  (last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= L_IDLE;
      addr_q <= '0;
      end_q  <= 1'b0;
    end else begin
      end_q <= 1'b0;
      // Leaving UPDATE_ALL from any active state aborts or finishes the load.
      if (st_q != L_IDLE && !upd) begin
        st_q   <= L_IDLE;
        addr_q <= '0;
      end else begin
        case (st_q)
          L_IDLE:  if (upd) st_q <= L_WAIT;
          L_WAIT:  if (bus.data_in_valid) st_q <= L_DRAIN;
          L_DRAIN: begin
            // Address saturates at the last entry; leftover entries of the beat are dropped.
            if (addr_q == AW'(CAM_DEPTH - 1)) begin
              st_q  <= L_DONE;
              end_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
              if (last) st_q <= L_WAIT;
            end
          end
          default: st_q <= st_q;
        endcase
      end
    end
  end
`ifdef CAM_LOAD_PERF_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else if (st_q == L_IDLE && upd) cyc_q <= '0;
    else if ((st_q == L_WAIT || st_q == L_DRAIN) && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
  end
  assign load_cycles = cyc_q;
`else
  assign load_cycles = '0;
`endif
endmodule

// File: tb/tb_cam_update_all_loader.sv
// tb_cam_update_all_loader: directed checks of the UPDATE_ALL loader at depth 64 and 20.
module tb_cam_update_all_loader;
  import cam_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] state_a = 3'd0;
  logic [2:0] state_b = 3'd0;
  logic end_a, end_b;
  logic [31:0] cyc_a, cyc_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cam_update_all_loader_if #(.C_DATA_WIDTH(512), .ENTRY_WIDTH(32), .CAM_DEPTH(64)) ifa ();
  cam_update_all_loader_if #(.C_DATA_WIDTH(512), .ENTRY_WIDTH(32), .CAM_DEPTH(20)) ifb ();
  cam_update_all_loader #(.C_DATA_WIDTH(512), .OP_CODE_WIDTH(3), .ENTRY_WIDTH(32), .CAM_DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .state(state_a), .bus(ifa.slave), .update_all_end(end_a), .load_cycles(cyc_a));
  cam_update_all_loader #(.C_DATA_WIDTH(512), .OP_CODE_WIDTH(3), .ENTRY_WIDTH(32), .CAM_DEPTH(20)) dut_b (
    .clk(clk), .rst(rst), .state(state_b), .bus(ifb.slave), .update_all_end(end_b), .load_cycles(cyc_b));

  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ifa.data_in = '0; ifa.data_in_valid = 1'b0;
    ifb.data_in = '0; ifb.data_in_valid = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({ifa.in_ready, ifa.wr_en, end_a, ifb.in_ready, ifb.wr_en, end_b} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b want 000000", {ifa.in_ready, ifa.wr_en, end_a, ifb.in_ready, ifb.wr_en, end_b}); end
    checks++;
    if (ifa.wr_addr !== 6'd0 || ifa.wr_data !== 32'd0 || cyc_a !== 32'd0)
      begin errors++; $display("FAIL reset_vals addr=%0d data=%h cyc=%0d want 0/0/0", ifa.wr_addr, ifa.wr_data, cyc_a); end
    tick;
    checks++;
    if (ifa.in_ready !== 1'b0 || ifa.wr_en !== 1'b0)
      begin errors++; $display("FAIL idle_hold rdy=%b wr_en=%b want 0/0", ifa.in_ready, ifa.wr_en); end
  endtask

  task automatic test_full_load;
    logic [31:0] exp_cyc;
`ifdef CAM_LOAD_PERF_CNT_EN
    exp_cyc = 32'd80;
`else
    exp_cyc = 32'd0;
`endif
    state_a = 3'd1;
    tick;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.wr_en !== 1'b0)
          begin errors++; $display("FAIL full_gap b=%0d rdy=%b wr_en=%b want 1/0", b, ifa.in_ready, ifa.wr_en); end
        tick;
      end
      ifa.data_in = mk(32'hA000_0000 + 32'(16 * b));
      ifa.data_in_valid = 1'b1;
      tick;
      ifa.data_in_valid = 1'b0;
      for (int e = 0; e < 16; e++) begin
        checks++;
        if (ifa.wr_en !== 1'b1 || ifa.in_ready !== 1'b0 || end_a !== 1'b0 || ifa.wr_addr !== 6'(16 * b + e) || ifa.wr_data !== 32'hA000_0000 + 32'(16 * b + e))
          begin errors++; $display("FAIL full_write en=%b rdy=%b end=%b addr=%0d data=%h want 1/0/0/%0d/%h", ifa.wr_en, ifa.in_ready, end_a, ifa.wr_addr, ifa.wr_data, 16 * b + e, 32'hA000_0000 + 32'(16 * b + e)); end
        tick;
      end
    end
    checks++;
    if (end_a !== 1'b1 || ifa.wr_en !== 1'b0 || ifa.in_ready !== 1'b0)
      begin errors++; $display("FAIL full_end_pulse end=%b en=%b rdy=%b want 1/0/0", end_a, ifa.wr_en, ifa.in_ready); end
    checks++;
    if (cyc_a !== exp_cyc) begin errors++; $display("FAIL full_load_cycles got %0d want %0d", cyc_a, exp_cyc); end
    tick;
    checks++;
    if (end_a !== 1'b0) begin errors++; $display("FAIL full_end_once got %b want 0", end_a); end
    checks++;
    if (cyc_a !== exp_cyc) begin errors++; $display("FAIL full_cycles_hold got %0d want %0d", cyc_a, exp_cyc); end
    state_a = 3'd0;
    tick;
    checks++;
    if (end_a !== 1'b0 || ifa.in_ready !== 1'b0 || cyc_a !== exp_cyc)
      begin errors++; $display("FAIL full_idle end=%b rdy=%b cyc=%0d want 0/0/%0d", end_a, ifa.in_ready, cyc_a, exp_cyc); end
    tick;
  endtask

  task automatic test_depth20;
    state_b = 3'd1;
    tick;
    ifb.data_in = mk(32'hA000_0000);
    ifb.data_in_valid = 1'b1;
    tick;
    ifb.data_in = mk(32'hA000_0010);
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (ifb.wr_en !== 1'b1 || ifb.in_ready !== 1'b0 || ifb.wr_addr !== 5'(e) || ifb.wr_data !== 32'hA000_0000 + 32'(e))
        begin errors++; $display("FAIL d20_beat1 en=%b rdy=%b addr=%0d data=%h want 1/0/%0d/%h", ifb.wr_en, ifb.in_ready, ifb.wr_addr, ifb.wr_data, e, 32'hA000_0000 + 32'(e)); end
      tick;
    end
    checks++;
    if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL d20_wait rdy=%b want 1", ifb.in_ready); end
    tick;
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (ifb.wr_en !== 1'b1 || ifb.wr_addr !== 5'(16 + e) || ifb.wr_data !== 32'hA000_0010 + 32'(e))
        begin errors++; $display("FAIL d20_beat2 en=%b addr=%0d data=%h want 1/%0d/%h", ifb.wr_en, ifb.wr_addr, ifb.wr_data, 16 + e, 32'hA000_0010 + 32'(e)); end
      tick;
    end
    checks++;
    if (end_b !== 1'b1 || ifb.wr_en !== 1'b0 || ifb.in_ready !== 1'b0)
      begin errors++; $display("FAIL d20_end end=%b en=%b rdy=%b want 1/0/0", end_b, ifb.wr_en, ifb.in_ready); end
    ifb.data_in = mk(32'hA000_0020);
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (ifb.in_ready !== 1'b0 || ifb.wr_en !== 1'b0 || end_b !== 1'b0)
        begin errors++; $display("FAIL d20_no_third rdy=%b en=%b end=%b want 0/0/0", ifb.in_ready, ifb.wr_en, end_b); end
    end
    ifb.data_in_valid = 1'b0;
    state_b = 3'd0;
    tick; tick;
  endtask

  task automatic test_hold_valid;
    state_a = 3'd1;
    ifa.data_in = mk(32'hA000_0000);
    ifa.data_in_valid = 1'b1;
    tick; tick;
    ifa.data_in = mk(32'hB000_0000);
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (ifa.wr_en !== 1'b1 || ifa.in_ready !== 1'b0 || ifa.wr_addr !== 6'(e) || ifa.wr_data !== 32'hA000_0000 + 32'(e))
        begin errors++; $display("FAIL hold_drain en=%b rdy=%b addr=%0d data=%h want 1/0/%0d/%h", ifa.wr_en, ifa.in_ready, ifa.wr_addr, ifa.wr_data, e, 32'hA000_0000 + 32'(e)); end
      tick;
    end
    checks++;
    if (ifa.in_ready !== 1'b1 || ifa.wr_en !== 1'b0)
      begin errors++; $display("FAIL hold_wait rdy=%b en=%b want 1/0", ifa.in_ready, ifa.wr_en); end
    tick;
    checks++;
    if (ifa.wr_en !== 1'b1 || ifa.wr_addr !== 6'd16 || ifa.wr_data !== 32'hB000_0000)
      begin errors++; $display("FAIL hold_next en=%b addr=%0d data=%h want 1/16/b0000000", ifa.wr_en, ifa.wr_addr, ifa.wr_data); end
    ifa.data_in_valid = 1'b0;
    state_a = 3'd0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    state_a = 3'd1;
    ifa.data_in = mk(32'hA000_0000);
    ifa.data_in_valid = 1'b1;
    tick; tick;
    ifa.data_in = mk(32'hA000_0010);
    repeat (17) tick;
    repeat (4) tick;
    checks++;
    if (ifa.wr_en !== 1'b1 || ifa.wr_addr !== 6'd20 || ifa.wr_data !== 32'hA000_0014)
      begin errors++; $display("FAIL rmid_fifth en=%b addr=%0d data=%h want 1/20/a0000014", ifa.wr_en, ifa.wr_addr, ifa.wr_data); end
    rst = 1'b1;
    ifa.data_in_valid = 1'b0;
    tick;
    checks++;
    if (ifa.wr_en !== 1'b0 || ifa.in_ready !== 1'b0 || end_a !== 1'b0 || ifa.wr_addr !== 6'd0)
      begin errors++; $display("FAIL rmid_reset en=%b rdy=%b end=%b addr=%0d want 0/0/0/0", ifa.wr_en, ifa.in_ready, end_a, ifa.wr_addr); end
    rst = 1'b0;
    tick;
    checks++;
    if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_restart_rdy got %b want 1", ifa.in_ready); end
    ifa.data_in = mk(32'hC000_0000);
    ifa.data_in_valid = 1'b1;
    tick;
    ifa.data_in_valid = 1'b0;
    checks++;
    if (ifa.wr_en !== 1'b1 || ifa.wr_addr !== 6'd0 || ifa.wr_data !== 32'hC000_0000)
      begin errors++; $display("FAIL rmid_restart en=%b addr=%0d data=%h want 1/0/c0000000", ifa.wr_en, ifa.wr_addr, ifa.wr_data); end
    state_a = 3'd0;
    tick; tick;
  endtask

  task automatic test_abort;
    state_a = 3'd1;
    tick;
    ifa.data_in = mk(32'hA000_0000);
    ifa.data_in_valid = 1'b1;
    tick;
    ifa.data_in_valid = 1'b0;
    repeat (16) tick;
    checks++;
    if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL abort_wait rdy=%b want 1", ifa.in_ready); end
    state_a = 3'd0;
    tick;
    checks++;
    if (ifa.in_ready !== 1'b0 || ifa.wr_en !== 1'b0 || end_a !== 1'b0 || ifa.wr_addr !== 6'd0)
      begin errors++; $display("FAIL abort_idle rdy=%b en=%b end=%b addr=%0d want 0/0/0/0", ifa.in_ready, ifa.wr_en, end_a, ifa.wr_addr); end
    tick;
    checks++;
    if (end_a !== 1'b0) begin errors++; $display("FAIL abort_no_pulse got %b want 0", end_a); end
    state_a = 3'd1;
    tick;
    ifa.data_in = mk(32'hD000_0000);
    ifa.data_in_valid = 1'b1;
    tick;
    ifa.data_in_valid = 1'b0;
    checks++;
    if (ifa.wr_en !== 1'b1 || ifa.wr_addr !== 6'd0 || ifa.wr_data !== 32'hD000_0000)
      begin errors++; $display("FAIL abort_restart en=%b addr=%0d data=%h want 1/0/d0000000", ifa.wr_en, ifa.wr_addr, ifa.wr_data); end
    state_a = 3'd0;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_depth20;
    test_hold_valid;
    test_reset_mid;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
